ppu_reg_port: RTL
=================

Name: ppu_reg_port

Overview:
- Parametrised CPU-facing register front end for the PPU. It decodes the mirrored $2000-$3FFF window into the 8 PPU registers and owns the shared write toggle, scroll and VRAM address registers, PPUSTATUS flags and NMI generation.
- VRAM is reached through a req/ack handshake with variable latency. OAM is reached through a simple synchronous port.
- Replaces the fixed-address register case logic inside the PPU top. Adds mirroring, a buffered PPUDATA read, read-clears-status and CPU stall.

Parameters:
- CPU_AW, 16, CPU address width.
- VRAM_AW, 14, VRAM address width; the VRAM address wraps modulo 2^VRAM_AW.
- OAM_AW, 8, OAM address width; OAMADDR wraps modulo 2^OAM_AW.
- REG_BASE, 'h2000, first decoded CPU address.
- REG_SPAN, 'h2000, decoded window size; must be a power of two and at least 8.
- OB_DECAY, 1048576, open-bus decay in clk cycles (used only when PPU_OPEN_BUS_EN is defined).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_addr  in  CPU_AW  CPU address
- cpu_re  in  1  read strobe, one cycle per access
- cpu_we  in  1  write strobe, one cycle per access
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data, valid when cpu_rvalid=1
- cpu_rvalid  out  1  one-cycle read-data pulse
- cpu_ready  out  1  0 while a PPUDATA access is outstanding
- vblank_set  in  1  pulse at start of vblank
- vblank_clr  in  1  pulse at pre-render line
- spr0_hit  in  1  level from sprite unit
- spr_ovf  in  1  level from sprite unit
- nmi  out  1  level = PPUCTRL[7] & vblank flag
- vram_req  out  1  held high until vram_ack
- vram_we  out  1  write when 1, read when 0
- vram_addr  out  VRAM_AW  VRAM address
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM read data, valid with vram_ack
- vram_ack  in  1  one-cycle completion
- oam_we  out  1  OAM write pulse
- oam_addr  out  OAM_AW  current OAMADDR
- oam_wdata  out  8  OAM write data
- oam_rdata  in  8  combinational OAM read data
- ppuctrl  out  8  PPUCTRL register
- ppumask  out  8  PPUMASK register
- scroll_x  out  8  horizontal scroll
- scroll_y  out  8  vertical scroll

Behaviour:
- Reset: all registers, write toggle w, vblank flag, buffer, nmi, vram_req, oam_we and cpu_rvalid go to 0; cpu_ready goes to 1; FSM goes to IDLE.
- Decode: hit when REG_BASE <= cpu_addr < REG_BASE+REG_SPAN; register index = cpu_addr[2:0]. Non-hit strobes are ignored and produce no rvalid.
- Strobes arriving while cpu_ready=0 are ignored. cpu_re and cpu_we together: the write wins.
- Non-PPUDATA reads: cpu_rdata and cpu_rvalid appear 1 cycle after cpu_re.
- Reg 0 write: PPUCTRL <= data. Reg 1 write: PPUMASK <= data.
- Reg 2 read returns {vblank, spr0_hit, spr_ovf, 5'b0}, then clears the vblank flag and w.
- Vblank flag set/clear: vblank_set sets it; vblank_clr clears it. vblank_set in the same cycle as a reg 2 read returns bit7=0 and leaves the flag clear (suppression). vblank_clr wins over vblank_set.
- Reg 3 write: OAMADDR <= data.
- Reg 4 write: oam_we pulses for 1 cycle, then OAMADDR increments (with wrap).
- Reg 4 read returns oam_rdata with no increment.
- Reg 5 write: w=0 loads scroll_x, w=1 loads scroll_y; w toggles.
- Reg 6 write: w=0 loads t[VRAM_AW-1:8] from data (upper bits masked); w=1 loads t[7:0] and then v <= t; w toggles.
- Reg 7 (PPUDATA) FSM: IDLE -> REQ on a reg 7 strobe; cpu_ready drops the next cycle. REQ holds vram_req with vram_addr=v until vram_ack, then -> DONE. DONE lasts 1 cycle, raises cpu_ready and returns to IDLE.
- Reg 7 write completes by writing VRAM.
- Reg 7 read, v below $3F00: cpu_rdata = old buffer, and buffer <= vram_rdata. Reg 7 read, v in $3F00-$3FFF: cpu_rdata = vram_rdata, and buffer is also loaded. cpu_rvalid pulses in DONE.
- v increments by 1, or by 32 when PPUCTRL[2]=1, in DONE, wrapping modulo 2^VRAM_AW. A reg 6 write cannot occur mid-access because cpu_ready=0.
- NMI: nmi follows PPUCTRL[7] & flag, registered with 1 cycle latency. Setting PPUCTRL[7] while the flag is set raises nmi again.
- Reset during a VRAM access: vram_req drops immediately and the FSM returns to IDLE. A late vram_ack is ignored.

Optional Feature:
- Macro: PPU_OPEN_BUS_EN.
- Defined: an 8-bit latch loads on every decoded write and read. Write-only register reads and reg 2 bits [4:0] return the latch. Each latch bit clears after OB_DECAY cycles without being refreshed, tracked by a single shared counter that restarts on every refresh.
- Undefined: those bits read 0.

Decomposition:
- Package ppu_pkg: register index enum (CTRL, MASK, STATUS, OAMADDR, OAMDATA, SCROLL, ADDR, DATA), FSM state enum, and the PALETTE_BASE constant 'h3F00.
- One sub-module, ppu_vram_xfer: the req/ack FSM plus the read buffer.

Test Plan:
- Write $2006=$21 then $2006=$08, then write $2007=$55 with ack latency 3 -> vram_addr=$2108, vram_wdata=$55; cpu_ready low for 5 cycles; v=$2109.
- Set PPUCTRL=$04, set v=$2000, read $2007 twice (vram returns $AA then $BB) -> rdata=$00 then $AA; v=$2040.
- Set v=$3F01, read $2007 with vram returning $0F -> rdata=$0F immediately.
- Pulse vblank_set with PPUCTRL=$80 -> nmi=1; read $2002 -> rdata[7]=1, nmi=0, and a second read gives rdata[7]=0. Then assert vblank_set in the same cycle as a $2002 read -> rdata=$00 and the flag stays 0.
- Write $3FFD (mirrors reg 5) with $12 then $2005 with $34 -> scroll_x=$12, scroll_y=$34. Then read $2002, then write $2005=$56 -> scroll_x=$56.
- Write $2003=$FF, then write $2004=$77 -> oam_we with addr $FF, then oam_addr=$00. Assert reset while vram_req=1 -> next cycle vram_req=0 and cpu_ready=1.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU CPU register port.
package ppu_pkg;

   typedef enum logic [2:0] {
      CTRL, MASK, STATUS, OAMADDR, OAMDATA, SCROLL, ADDR, DATA
   } reg_idx_e;

   typedef enum logic [1:0] {
      ST_IDLE, ST_REQ, ST_DONE
   } xfer_state_e;

   localparam int unsigned PALETTE_BASE = 'h3F00;
   localparam int unsigned PALETTE_SIZE = 'h100;

endpackage

// File: rtl/ppu_vram_xfer.sv
// PPUDATA access engine: req/ack handshake with VRAM plus the delayed-read buffer.
module ppu_vram_xfer
   import ppu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,
   input  logic       i_we,
   input  logic [7:0] i_wdata,
   input  logic       i_palette,
   input  logic [7:0] i_vram_rdata,
   input  logic       i_vram_ack,
   output logic       o_req,
   output logic       o_we,
   output logic [7:0] o_wdata,
   output logic       o_ready,
   output logic       o_done_c,
   output logic       o_rd_ack_c,
   output logic [7:0] o_rd_data_c
);

   xfer_state_e r_state, w_next;
   logic        r_req, r_ready, r_we;
   logic [7:0]  r_wdata, r_buf;

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (i_start) w_next = ST_REQ;
         ST_REQ:  if (i_vram_ack) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Handshake flags track the next state so they line up with it cycle for cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_req   <= 1'b0;
         r_ready <= 1'b1;
         r_we    <= 1'b0;
         r_wdata <= 8'h00;
         r_buf   <= 8'h00;
      end else begin
         r_req   <= (w_next == ST_REQ);
         r_ready <= (w_next == ST_IDLE);
         if (r_state == ST_IDLE && i_start) begin
            r_we    <= i_we;
            r_wdata <= i_wdata;
         end
         if (o_rd_ack_c) r_buf <= i_vram_rdata;
      end
   end

   assign o_req       = r_req;
   assign o_we        = r_we;
   assign o_wdata     = r_wdata;
   assign o_ready     = r_ready;
   assign o_done_c    = (r_state == ST_DONE);
   assign o_rd_ack_c  = (r_state == ST_REQ) && i_vram_ack && !r_we;
   // Palette reads bypass the buffer; everything else returns the previous fetch.
   assign o_rd_data_c = i_palette ? i_vram_rdata : r_buf;

endmodule

// File: rtl/ppu_reg_port.sv
// CPU-facing PPU register front end: mirrored decode, scroll/address latches, status and NMI.
// Open-bus latch with decay is enabled by defining PPU_OPEN_BUS_EN.
module ppu_reg_port
   import ppu_pkg::*;
#(
   parameter int unsigned CPU_AW   = 16,
   parameter int unsigned VRAM_AW  = 14,
   parameter int unsigned OAM_AW   = 8,
   parameter int unsigned REG_BASE = 'h2000,
   parameter int unsigned REG_SPAN = 'h2000,
   parameter int unsigned OB_DECAY = 1048576
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [CPU_AW-1:0]  cpu_addr,
   input  logic               cpu_re,
   input  logic               cpu_we,
   input  logic [7:0]         cpu_wdata,
   output logic [7:0]         cpu_rdata,
   output logic               cpu_rvalid,
   output logic               cpu_ready,
   input  logic               vblank_set,
   input  logic               vblank_clr,
   input  logic               spr0_hit,
   input  logic               spr_ovf,
   output logic               nmi,
   output logic               vram_req,
   output logic               vram_we,
   output logic [VRAM_AW-1:0] vram_addr,
   output logic [7:0]         vram_wdata,
   input  logic [7:0]         vram_rdata,
   input  logic               vram_ack,
   output logic               oam_we,
   output logic [OAM_AW-1:0]  oam_addr,
   output logic [7:0]         oam_wdata,
   input  logic [7:0]         oam_rdata,
   output logic [7:0]         ppuctrl,
   output logic [7:0]         ppumask,
   output logic [7:0]         scroll_x,
   output logic [7:0]         scroll_y
);

   localparam int unsigned TH = VRAM_AW - 8;

   logic [7:0]         r_ctrl, r_mask, r_scroll_x, r_scroll_y, r_rdata, r_oam_wdata;
   logic               r_w, r_vblank, r_nmi, r_rvalid, r_oam_we;
   logic [OAM_AW-1:0]  r_oam_addr;
   logic [VRAM_AW-1:0] r_v, r_t;
   logic               w_hit, w_wr, w_rd, w_status_rd, w_start, w_pal;
   logic               w_ready, w_done, w_rd_ack;
   logic [7:0]         w_rd_val, w_xfer_rdata, w_ob;
   reg_idx_e           w_idx;

   assign w_hit       = (32'(cpu_addr) >= REG_BASE) && (32'(cpu_addr) < REG_BASE + REG_SPAN);
   assign w_idx       = reg_idx_e'(cpu_addr[2:0]);
   assign w_wr        = cpu_we & w_hit & w_ready;
   assign w_rd        = cpu_re & ~cpu_we & w_hit & w_ready;
   assign w_status_rd = w_rd & (w_idx == STATUS);
   assign w_start     = (w_wr | w_rd) & (w_idx == DATA);
   assign w_pal       = (32'(r_v) >= PALETTE_BASE) && (32'(r_v) < PALETTE_BASE + PALETTE_SIZE);

   always_comb begin
      w_rd_val = w_ob;
      case (w_idx)
         STATUS:  w_rd_val = {r_vblank, spr0_hit, spr_ovf, w_ob[4:0]};
         OAMDATA: w_rd_val = oam_rdata;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl      <= 8'h00;
         r_mask      <= 8'h00;
         r_scroll_x  <= 8'h00;
         r_scroll_y  <= 8'h00;
         r_rdata     <= 8'h00;
         r_oam_wdata <= 8'h00;
         r_w         <= 1'b0;
         r_vblank    <= 1'b0;
         r_nmi       <= 1'b0;
         r_rvalid    <= 1'b0;
         r_oam_we    <= 1'b0;
         r_oam_addr  <= '0;
         r_v         <= '0;
         r_t         <= '0;
      end else begin
         r_nmi <= r_ctrl[7] & r_vblank;
         // Clear wins over set; a status read in the set cycle suppresses the flag.
         if (vblank_clr || w_status_rd) r_vblank <= 1'b0;
         else if (vblank_set)           r_vblank <= 1'b1;

         r_rvalid <= 1'b0;
         if (w_rd_ack) begin
            r_rdata  <= w_xfer_rdata;
            r_rvalid <= 1'b1;
         end else if (w_rd && w_idx != DATA) begin
            r_rdata  <= w_rd_val;
            r_rvalid <= 1'b1;
         end

         r_oam_we <= 1'b0;
         if (r_oam_we) r_oam_addr <= r_oam_addr + OAM_AW'(1);
         if (w_done)   r_v <= r_v + (r_ctrl[2] ? VRAM_AW'(32) : VRAM_AW'(1));
         if (w_status_rd) r_w <= 1'b0;

         if (w_wr) begin
            case (w_idx)
               CTRL:    r_ctrl <= cpu_wdata;
               MASK:    r_mask <= cpu_wdata;
               OAMADDR: r_oam_addr <= OAM_AW'(cpu_wdata);
               OAMDATA: begin
                  r_oam_we    <= 1'b1;
                  r_oam_wdata <= cpu_wdata;
               end
               SCROLL: begin
                  if (!r_w) r_scroll_x <= cpu_wdata;
                  else      r_scroll_y <= cpu_wdata;
                  r_w <= ~r_w;
               end
               ADDR: begin
                  if (!r_w) begin
                     r_t[VRAM_AW-1:8] <= cpu_wdata[TH-1:0];
                  end else begin
                     r_t[7:0] <= cpu_wdata;
                     r_v      <= {r_t[VRAM_AW-1:8], cpu_wdata};
                  end
                  r_w <= ~r_w;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef PPU_OPEN_BUS_EN
   localparam int unsigned OB_CW = $clog2(OB_DECAY + 1);
   logic [7:0]       r_ob;
   logic [OB_CW-1:0] r_ob_cnt;

   // One shared decay counter; any bus refresh restarts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ob     <= 8'h00;
         r_ob_cnt <= '0;
      end else if (w_wr) begin
         r_ob     <= cpu_wdata;
         r_ob_cnt <= '0;
      end else if (w_rd && w_idx != DATA) begin
         r_ob     <= w_rd_val;
         r_ob_cnt <= '0;
      end else if (w_rd_ack) begin
         r_ob     <= w_xfer_rdata;
         r_ob_cnt <= '0;
      end else if (r_ob_cnt == OB_CW'(OB_DECAY - 1)) begin
         r_ob <= 8'h00;
      end else begin
         r_ob_cnt <= r_ob_cnt + OB_CW'(1);
      end
   end
   assign w_ob = r_ob;
`else
   logic w_unused_ob;
   assign w_unused_ob = (OB_DECAY == 0);
   assign w_ob        = 8'h00;
`endif

   ppu_vram_xfer u_xfer (
      .clk          (clk),
      .reset        (reset),
      .i_start      (w_start),
      .i_we         (cpu_we),
      .i_wdata      (cpu_wdata),
      .i_palette    (w_pal),
      .i_vram_rdata (vram_rdata),
      .i_vram_ack   (vram_ack),
      .o_req        (vram_req),
      .o_we         (vram_we),
      .o_wdata      (vram_wdata),
      .o_ready      (w_ready),
      .o_done_c     (w_done),
      .o_rd_ack_c   (w_rd_ack),
      .o_rd_data_c  (w_xfer_rdata)
   );

   assign cpu_ready  = w_ready;
   assign cpu_rdata  = r_rdata;
   assign cpu_rvalid = r_rvalid;
   assign nmi        = r_nmi;
   assign vram_addr  = r_v;
   assign oam_we     = r_oam_we;
   assign oam_addr   = r_oam_addr;
   assign oam_wdata  = r_oam_wdata;
   assign ppuctrl    = r_ctrl;
   assign ppumask    = r_mask;
   assign scroll_x   = r_scroll_x;
   assign scroll_y   = r_scroll_y;

endmodule
